demux_param_buf: RTL and testbench

Buffered 1-to-2 demultiplexer with valid/ready handshakes. It steers an N-bit result word from one producer to one of two consumer lanes, chosen by a per-word select bit, and holds each lane's words in its own DEPTH-entry FIFO. It performs the inverse of the 2:1 N-bit select mux used in the carry-select adder datapaths. Its job is to distribute adder results or operands to two downstream adder pipelines, and it absorbs backpressure independently on each lane.

---
 rtl/demux_param_buf.sv | 92 +++++++++
 tb/tb_demux_param_buf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux_param_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux_param_buf
// Description : Buffered 1-to-2 demultiplexer. Each word is steered by in_sel
//               into one of two independent DEPTH-entry FIFO lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_param_buf #(
    parameter int N     = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [N-1:0]               out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [N-1:0]               out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH+1)-1:0] lvl0,
    output logic [$clog2(DEPTH+1)-1:0] lvl1
);

    localparam int              c_lw   = $clog2(DEPTH + 1);
    localparam int              c_pw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);
    localparam logic [c_lw-1:0] c_one  = c_lw'(1);
    localparam logic [c_pw-1:0] c_last = c_pw'(DEPTH - 1);
    localparam logic [c_pw-1:0] c_pone = c_pw'(1);

    logic [1:0]           w_push;
    logic [1:0]           w_pop;
    logic [1:0]           w_oready;
    logic [1:0][N-1:0]    w_head;
    logic [1:0][c_lw-1:0] w_lvl;

    assign w_oready = {out1_ready, out0_ready};

    // Only registered occupancy feeds in_ready, so a full lane stays closed
    // even in a cycle where it is also popping.
    assign in_ready = rst_n && !(in_sel ? (w_lvl[1] == c_full) : (w_lvl[0] == c_full));

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [N-1:0]    r_mem [DEPTH];
        logic [c_pw-1:0] r_wptr;
        logic [c_pw-1:0] r_rptr;
        logic [c_lw-1:0] r_cnt;

        assign w_push[l] = in_valid && in_ready && (in_sel == (l == 1));
        assign w_pop[l]  = (r_cnt != '0) && w_oready[l];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[l]) begin
                    r_mem[r_wptr] <= in_data;
                    r_wptr        <= (r_wptr == c_last) ? '0 : r_wptr + c_pone;
                end
                if (w_pop[l]) begin
                    r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + c_pone;
                end
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_cnt <= r_cnt + c_one;
                    2'b01:   r_cnt <= r_cnt - c_one;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        assign w_head[l] = r_mem[r_rptr];
        assign w_lvl[l]  = r_cnt;
    end

    assign out0_data  = w_head[0];
    assign out1_data  = w_head[1];
    assign out0_valid = (w_lvl[0] != '0);
    assign out1_valid = (w_lvl[1] != '0);
    assign lvl0       = w_lvl[0];
    assign lvl1       = w_lvl[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_param_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_param_buf
// Description : Directed bench for demux_param_buf (DEPTH=2 and DEPTH=3 units).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_param_buf;

    logic       clk;
    logic       rst_n;
    int         checks;
    int         errors;

    // DEPTH = 2 instance
    logic [3:0] in_data;
    logic       in_sel, in_valid, in_ready;
    logic [3:0] out0_data, out1_data;
    logic       out0_valid, out1_valid, out0_ready, out1_ready;
    logic [1:0] lvl0, lvl1;

    // DEPTH = 3 instance
    logic [3:0] b_in_data;
    logic       b_in_sel, b_in_valid, b_in_ready;
    logic [3:0] b_out0_data, b_out1_data;
    logic       b_out0_valid, b_out1_valid, b_out0_ready, b_out1_ready;
    logic [1:0] b_lvl0, b_lvl1;

    demux_param_buf #(.N(4), .DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .lvl0(lvl0), .lvl1(lvl1)
    );

    demux_param_buf #(.N(4), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out0_data(b_out0_data), .out0_valid(b_out0_valid), .out0_ready(b_out0_ready),
        .out1_data(b_out1_data), .out1_valid(b_out1_valid), .out1_ready(b_out1_ready),
        .lvl0(b_lvl0), .lvl1(b_lvl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b want 00", out1_valid, out0_valid); end
        checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) begin errors++; $display("FAIL rst_lvl got %0d/%0d want 0/0", lvl0, lvl1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
        checks++; if (out0_data !== 4'h0 || out1_data !== 4'h0) begin errors++; $display("FAIL post_rst_data got %h/%h want 0/0", out0_data, out1_data); end
        // one word into each lane, then an asynchronous reset mid-cycle
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
        @(negedge clk);
        in_sel = 1'b1; in_data = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (lvl0 !== 2'd1 || lvl1 !== 2'd1) begin errors++; $display("FAIL pre_rst_lvl got %0d/%0d want 1/1", lvl0, lvl1); end
        checks++; if (out0_data !== 4'h3 || out1_data !== 4'h9) begin errors++; $display("FAIL pre_rst_data got %h/%h want 3/9", out0_data, out1_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b%b want 00", out1_valid, out0_valid); end
        checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) begin errors++; $display("FAIL async_rst_lvl got %0d/%0d want 0/0", lvl0, lvl1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_in_ready got %b want 0", in_ready); end
        checks++; if (out0_data !== 4'h0 || out1_data !== 4'h0) begin errors++; $display("FAIL async_rst_data got %h/%h want 0/0", out0_data, out1_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL release got rdy=%b v=%b%b want rdy=1 v=00", in_ready, out1_valid, out0_valid); end
        checks++; if (out0_data !== 4'h0 || out1_data !== 4'h0) begin errors++; $display("FAIL release_data got %h/%h want 0/0", out0_data, out1_data); end
    endtask

    task automatic test_routing;
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hA;
        @(negedge clk);
        checks++; if (out0_valid !== 1'b1 || out0_data !== 4'hA) begin errors++; $display("FAIL route0 got v=%b d=%h want v=1 d=a", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route0_lane1 got v=%b want 0", out1_valid); end
        in_sel = 1'b1; in_data = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL route0_once got v=%b want 0", out0_valid); end
        checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h5) begin errors++; $display("FAIL route1 got v=%b d=%h want v=1 d=5", out1_valid, out1_data); end
        @(negedge clk);
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route1_once got v=%b want 0", out1_valid); end
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask

    task automatic test_full_backpressure;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        in_data = 4'h3;
        #1;
        checks++; if (lvl0 !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL full got lvl0=%0d rdy=%b want 2/0", lvl0, in_ready); end
        @(negedge clk);
        checks++; if (lvl0 !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL full_hold got lvl0=%0d rdy=%b want 2/0", lvl0, in_ready); end
        in_sel = 1'b1; in_data = 4'hE;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lane1_open got %b want 1", in_ready); end
        @(negedge clk);
        checks++; if (lvl1 !== 2'd1 || out1_data !== 4'hE || lvl0 !== 2'd2) begin errors++; $display("FAIL lane1_push got lvl1=%0d d=%h lvl0=%0d want 1/e/2", lvl1, out1_data, lvl0); end
        checks++; if (out0_data !== 4'h1) begin errors++; $display("FAIL head_first got %h want 1", out0_data); end
        in_sel = 1'b0; in_data = 4'h3; out0_ready = 1'b1;
        @(negedge clk);
        checks++; if (lvl0 !== 2'd1 || out0_data !== 4'h2 || in_ready !== 1'b1) begin errors++; $display("FAIL pop1 got lvl0=%0d d=%h rdy=%b want 1/2/1", lvl0, out0_data, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (lvl0 !== 2'd1 || out0_data !== 4'h3) begin errors++; $display("FAIL pop2 got lvl0=%0d d=%h want 1/3", lvl0, out0_data); end
        @(negedge clk);
        checks++; if (lvl0 !== 2'd0 || out0_valid !== 1'b0) begin errors++; $display("FAIL pop3 got lvl0=%0d v=%b want 0/0", lvl0, out0_valid); end
        out0_ready = 1'b0; out1_ready = 1'b1;
        @(negedge clk);
        out1_ready = 1'b0;
        checks++; if (lvl1 !== 2'd0) begin errors++; $display("FAIL drain1 got lvl1=%0d want 0", lvl1); end
    endtask

    task automatic test_simul_push_pop;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h4;
        @(negedge clk);
        in_data = 4'h7; out0_ready = 1'b1;
        checks++; if (lvl0 !== 2'd1 || out0_data !== 4'h4) begin errors++; $display("FAIL pp_pre got lvl0=%0d d=%h want 1/4", lvl0, out0_data); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (lvl0 !== 2'd1 || out0_data !== 4'h7) begin errors++; $display("FAIL pp got lvl0=%0d d=%h want 1/7", lvl0, out0_data); end
        @(negedge clk);
        out0_ready = 1'b0;
        checks++; if (lvl0 !== 2'd0) begin errors++; $display("FAIL pp_drain got lvl0=%0d want 0", lvl0); end
    endtask

    task automatic test_dual_pop;
        in_valid = 1'b1;
        in_sel = 1'b0; in_data = 4'h8; @(negedge clk);
        in_sel = 1'b1; in_data = 4'hC; @(negedge clk);
        in_sel = 1'b0; in_data = 4'h9; @(negedge clk);
        in_sel = 1'b1; in_data = 4'hD; @(negedge clk);
        in_valid = 1'b0;
        checks++; if (lvl0 !== 2'd2 || lvl1 !== 2'd2) begin errors++; $display("FAIL dual_fill got %0d/%0d want 2/2", lvl0, lvl1); end
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(negedge clk);
        checks++; if (lvl0 !== 2'd1 || lvl1 !== 2'd1 || out0_data !== 4'h9 || out1_data !== 4'hD) begin errors++; $display("FAIL dual_pop1 got %0d/%0d %h/%h want 1/1 9/d", lvl0, lvl1, out0_data, out1_data); end
        @(negedge clk);
        out0_ready = 1'b0; out1_ready = 1'b0;
        checks++; if (lvl0 !== 2'd0 || lvl1 !== 2'd0) begin errors++; $display("FAIL dual_pop2 got %0d/%0d want 0/0", lvl0, lvl1); end
    endtask

    task automatic test_wrap;
        int sent;
        int rcvd;
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 16; cyc++) begin
            @(negedge clk);
            checks++; if (b_lvl1 > 2'd3 || b_out0_valid !== 1'b0) begin errors++; $display("FAIL wrap_lvl got lvl1=%0d v0=%b want <=3/0", b_lvl1, b_out0_valid); end
            b_out1_ready = 1'($urandom_range(0, 1));
            if (b_out1_valid && b_out1_ready) begin
                checks++; if (b_out1_data !== 4'(rcvd)) begin errors++; $display("FAIL wrap_data got %h want %h", b_out1_data, 4'(rcvd)); end
                rcvd++;
            end
            b_in_sel   = 1'b1;
            b_in_valid = (sent < 16);
            b_in_data  = 4'(sent);
            #1;
            if (b_in_valid && b_in_ready) sent++;
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out1_ready = 1'b0;
        checks++; if (rcvd !== 16 || sent !== 16) begin errors++; $display("FAIL wrap_count got sent=%0d rcvd=%0d want 16/16", sent, rcvd); end
        checks++; if (b_lvl1 !== 2'd0 || b_out1_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got lvl1=%0d v=%b want 0/0", b_lvl1, b_out1_valid); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_data = '0; in_sel = 1'b0; in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        b_in_data = '0; b_in_sel = 1'b0; b_in_valid = 1'b0; b_out0_ready = 1'b0; b_out1_ready = 1'b0;
        test_reset();
        test_routing();
        test_full_backpressure();
        test_simul_push_pop();
        test_dual_pop();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
